rst_seq_ctrl: RTL and testbench

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

---
 rtl/rst_seq_ctrl_pkg.sv | 18 +
 rtl/rst_seq_ctrl_cnt.sv | 43 ++++
 rtl/rst_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl_pkg
// Shared definitions for the reset/enable sequencer:
//   - seq_state_e : controller state encoding (IDLE / RELEASE / UP / ASSERT)
//   - MAX_STAGES  : upper bound on the number of sequenced stages
// ----------------------------------------------------------------------------
package rst_seq_ctrl_pkg;

  localparam int MAX_STAGES = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_UP      = 2'd2,
    ST_ASSERT  = 2'd3
  } seq_state_e;

endpackage : rst_seq_ctrl_pkg

// File: rtl/rst_seq_ctrl_cnt.sv
// ----------------------------------------------------------------------------
// rst_seq_cnt
// Loadable down-counter with an expire flag, shared by the release and
// re-assert phases of the sequencer.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset (clears the count)
//   load_i     : load load_val_i (a value of 0 is loaded as 1)
//   load_val_i : delay to load, in cycles
//   en_i       : count enable
//   expire_o   : high while enabled with a count of 1; the controller acts
//                on it at the coming edge, which is exactly load_val cycles
//                after the load edge
// ----------------------------------------------------------------------------
module rst_seq_cnt
  import rst_seq_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (load_i) begin
      // A zero delay would never reach the expire value, so run it as one cycle.
      cnt_reg <= (load_val_i == '0) ? CNT_W'(1) : load_val_i;
    end else if (en_i && (cnt_reg != '0)) begin
      // Saturate at zero instead of wrapping.
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign expire_o = en_i && (cnt_reg == CNT_W'(1));

endmodule : rst_seq_cnt

// File: rtl/rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// rst_seq_ctrl
// Sequences NUM_STAGES reset/enable outputs: releases them in order 0..N-1
// with a per-stage delay, and re-asserts them in reverse order on request.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset, overrides all requests
//   start_i    : start the release sequence (only looked at in IDLE)
//   down_req_i : start the re-assert sequence (UP), or abort a release
//   delay_i    : per-stage delays, stage k at [k*CNT_W +: CNT_W]
//   stage_o    : per-stage released flag XOR INV_MASK (registered)
//   busy_o     : high while releasing or re-asserting
//   up_o       : high while all stages are released
//   done_o     : one-cycle pulse when a release or assert sequence finishes
// ----------------------------------------------------------------------------
module rst_seq_ctrl
  import rst_seq_ctrl_pkg::*;
#(
  parameter int                    NUM_STAGES = 5,
  parameter int                    CNT_W      = 16,
  parameter logic [NUM_STAGES-1:0] INV_MASK   = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic                        down_req_i,
  input  logic [NUM_STAGES*CNT_W-1:0] delay_i,
  output logic [NUM_STAGES-1:0]       stage_o,
  output logic                        busy_o,
  output logic                        up_o,
  output logic                        done_o
);

  localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  if ((NUM_STAGES < 1) || (NUM_STAGES > MAX_STAGES)) begin : g_bad_num_stages
    $error("rst_seq_ctrl: NUM_STAGES out of range");
  end

  seq_state_e                  state_reg;
  logic [IDX_W-1:0]            idx_reg;
  logic [NUM_STAGES*CNT_W-1:0] dly_reg;

  logic [IDX_W-1:0] idx_inc;
  logic [IDX_W-1:0] idx_dec;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_expire;

  // Per-stage views of the captured delays and of the live delay input.
  logic [CNT_W-1:0] dly_cap [NUM_STAGES];
  logic [CNT_W-1:0] dly_in  [NUM_STAGES];

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_dly_view
    assign dly_cap[gi] = dly_reg[gi*CNT_W +: CNT_W];
    assign dly_in[gi]  = delay_i[gi*CNT_W +: CNT_W];
  end

  assign idx_inc = idx_reg + 1'b1;
  assign idx_dec = idx_reg - 1'b1;
  assign cnt_en  = (state_reg == ST_RELEASE) || (state_reg == ST_ASSERT);

  // Counter reload decisions. The edge that enters RELEASE/ASSERT from
  // IDLE/UP loads straight from delay_i, because the capture register only
  // takes the new value at that same edge. Later stages chain back-to-back:
  // the next delay is loaded on the expiring edge so there is no gap cycle.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = dly_cap[idx_reg];
    unique case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          cnt_load     = 1'b1;
          cnt_load_val = dly_in[0];
        end
      end
      ST_RELEASE: begin
        if (down_req_i) begin
          // Abort: unwind from the highest already-released stage.
          if (idx_reg != '0) begin
            cnt_load     = 1'b1;
            cnt_load_val = dly_cap[idx_dec];
          end
        end else if (cnt_expire && (idx_reg != LAST_IDX)) begin
          cnt_load     = 1'b1;
          cnt_load_val = dly_cap[idx_inc];
        end
      end
      ST_UP: begin
        if (down_req_i) begin
          cnt_load     = 1'b1;
          cnt_load_val = dly_in[LAST_IDX];
        end
      end
      ST_ASSERT: begin
        if (cnt_expire && (idx_reg != '0)) begin
          cnt_load     = 1'b1;
          cnt_load_val = dly_cap[idx_dec];
        end
      end
      default: ;
    endcase
  end

  rst_seq_cnt #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .expire_o   (cnt_expire)
  );

  // Controller FSM. stage_o holds the polarity-adjusted value directly, so
  // a released stage is driven to ~INV_MASK[k] and a held stage to INV_MASK[k].
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      dly_reg   <= '0;
      stage_o   <= INV_MASK;
      busy_o    <= 1'b0;
      up_o      <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      unique case (state_reg)
        ST_IDLE: begin
          if (start_i) begin
            state_reg <= ST_RELEASE;
            idx_reg   <= '0;
            dly_reg   <= delay_i;
            busy_o    <= 1'b1;
          end
        end
        ST_RELEASE: begin
          if (down_req_i) begin
            if (idx_reg == '0) begin
              // Nothing released yet: quietly fall back to IDLE.
              state_reg <= ST_IDLE;
              busy_o    <= 1'b0;
            end else begin
              state_reg <= ST_ASSERT;
              idx_reg   <= idx_dec;
            end
          end else if (cnt_expire) begin
            stage_o[idx_reg] <= ~INV_MASK[idx_reg];
            if (idx_reg == LAST_IDX) begin
              state_reg <= ST_UP;
              busy_o    <= 1'b0;
              up_o      <= 1'b1;
              done_o    <= 1'b1;
            end else begin
              idx_reg <= idx_inc;
            end
          end
        end
        ST_UP: begin
          if (down_req_i) begin
            state_reg <= ST_ASSERT;
            idx_reg   <= LAST_IDX;
            dly_reg   <= delay_i;
            busy_o    <= 1'b1;
            up_o      <= 1'b0;
          end
        end
        ST_ASSERT: begin
          if (cnt_expire) begin
            stage_o[idx_reg] <= INV_MASK[idx_reg];
            if (idx_reg == '0) begin
              state_reg <= ST_IDLE;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
            end else begin
              idx_reg <= idx_dec;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule : rst_seq_ctrl

// File: tb/tb_rst_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_rst_seq_ctrl
// Scoreboard bench for rst_seq_ctrl (3 stages, 8-bit delays, INV_MASK=011).
// Expected output changes, with the edge at which they must appear, are
// queued as stimulus is driven; a negedge monitor pops one entry for every
// change it sees on {stage_o, up_o, done_o, busy_o}.
// ----------------------------------------------------------------------------
module tb_rst_seq_ctrl;

  localparam int N = 3;
  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic           down_req_i;
  logic [N*W-1:0] delay_i;
  logic [N-1:0]   stage_o;
  logic           busy_o;
  logic           up_o;
  logic           done_o;

  rst_seq_ctrl #(
    .NUM_STAGES (N),
    .CNT_W      (W),
    .INV_MASK   (3'b011)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_i),
    .down_req_i (down_req_i),
    .delay_i    (delay_i),
    .stage_o    (stage_o),
    .busy_o     (busy_o),
    .up_o       (up_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Edge counter: after the e-th rising edge, cyc == e.
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] val;   // {stage[2:0], up, done, busy}
  } evt_t;

  evt_t       exp_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic       mon_en   = 1'b0;
  logic [5:0] prev_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] st, input logic up, input logic dn,
                      input logic bz);
    evt_t e;
    e.cyc = c;
    e.val = {st, up, dn, bz};
    exp_q.push_back(e);
  endtask

  // Return 1 time unit after rising edge e.
  task automatic wait_edge(input int e);
    while (cyc < e) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Make a signal high so that it is sampled at exactly edge e.
  // which: 0=start, 1=down_req, 2=both
  task automatic pulse(input int which, input int e);
    wait_edge(e - 1);
    if (which != 1) start_i = 1'b1;
    if (which != 0) down_req_i = 1'b1;
    wait_edge(e);
    start_i    = 1'b0;
    down_req_i = 1'b0;
  endtask

  // Monitor: every output change must match the head of the queue.
  always @(negedge clk_i) begin
    logic [5:0] snap;
    evt_t       e;
    if (mon_en) begin
      snap = {stage_o, up_o, done_o, busy_o};
      if (snap !== prev_val) begin
        $display("txn cyc=%0d stage=%b up=%b done=%b busy=%b",
                 cyc, stage_o, up_o, done_o, busy_o);
        if (exp_q.size() == 0) begin
          chk("unexpected_evt", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("evt_cyc", cyc, e.cyc);
          chk("evt_val", {26'd0, snap}, {26'd0, e.val});
        end
        prev_val = snap;
      end
    end
  end

  initial begin
    rst_i      = 1'b1;
    start_i    = 1'b0;
    down_req_i = 1'b0;
    delay_i    = {8'd3, 8'd2, 8'd4};

    wait_edge(3);
    chk("rst_stage", {29'd0, stage_o}, 32'h3);
    chk("rst_busy", {31'd0, busy_o}, 0);
    chk("rst_up", {31'd0, up_o}, 0);
    chk("rst_done", {31'd0, done_o}, 0);
    rst_i    = 1'b0;
    prev_val = {stage_o, up_o, done_o, busy_o};
    mon_en   = 1'b1;

    // Full release, delays {4,2,3}: 011 -> 010 -> 000 -> 100.
    push(10, 3'b011, 0, 0, 1);
    push(14, 3'b010, 0, 0, 1);
    push(16, 3'b000, 0, 0, 1);
    push(19, 3'b100, 1, 1, 0);
    push(20, 3'b100, 1, 0, 0);
    pulse(0, 10);

    // Re-assert from UP: stage 2,1,0 at +3,+5,+9. delay_i changed and
    // start pulsed mid-sequence must both be ignored.
    push(25, 3'b100, 0, 0, 1);
    push(28, 3'b000, 0, 0, 1);
    push(30, 3'b010, 0, 0, 1);
    push(34, 3'b011, 0, 1, 0);
    push(35, 3'b011, 0, 0, 0);
    pulse(1, 25);
    wait_edge(26);
    delay_i = {8'd9, 8'd9, 8'd9};
    pulse(0, 29);
    wait_edge(36);
    delay_i = {8'd3, 8'd0, 8'd4};

    // down_req in IDLE is ignored; start+down together in IDLE -> start wins.
    // Stage 1 delay of 0 runs as 1.
    pulse(1, 37);
    push(40, 3'b011, 0, 0, 1);
    push(44, 3'b010, 0, 0, 1);
    push(45, 3'b000, 0, 0, 1);
    push(48, 3'b100, 1, 1, 0);
    push(49, 3'b100, 1, 0, 0);
    pulse(2, 40);
    push(52, 3'b100, 0, 0, 1);
    push(55, 3'b000, 0, 0, 1);
    push(56, 3'b010, 0, 0, 1);
    push(60, 3'b011, 0, 1, 0);
    push(61, 3'b011, 0, 0, 0);
    pulse(1, 52);

    // Abort one cycle after stage 0 releases: stage 0 re-asserts d0 later.
    wait_edge(65);
    delay_i = {8'd3, 8'd2, 8'd4};
    push(70, 3'b011, 0, 0, 1);
    push(74, 3'b010, 0, 0, 1);
    push(79, 3'b011, 0, 1, 0);
    push(80, 3'b011, 0, 0, 0);
    pulse(0, 70);
    pulse(1, 75);

    // Abort before any stage released: straight to IDLE, no done pulse.
    push(90, 3'b011, 0, 0, 1);
    push(92, 3'b011, 0, 0, 0);
    pulse(0, 90);
    pulse(1, 92);

    // Reset while stage 1 is counting, with start held high: reset wins.
    push(100, 3'b011, 0, 0, 1);
    push(104, 3'b010, 0, 0, 1);
    push(105, 3'b011, 0, 0, 0);
    pulse(0, 100);
    wait_edge(104);
    rst_i   = 1'b1;
    start_i = 1'b1;
    wait_edge(105);
    rst_i   = 1'b0;
    start_i = 1'b0;

    // Maximum 8-bit delay on stage 1, minimum on the others.
    wait_edge(110);
    delay_i = {8'd1, 8'd255, 8'd1};
    push(120, 3'b011, 0, 0, 1);
    push(121, 3'b010, 0, 0, 1);
    push(376, 3'b000, 0, 0, 1);
    push(377, 3'b100, 1, 1, 0);
    push(378, 3'b100, 1, 0, 0);
    pulse(0, 120);
    push(380, 3'b100, 0, 0, 1);
    push(381, 3'b000, 0, 0, 1);
    push(636, 3'b010, 0, 0, 1);
    push(637, 3'b011, 0, 1, 0);
    push(638, 3'b011, 0, 0, 0);
    pulse(1, 380);

    wait_edge(650);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rst_seq_ctrl
